// File: rtl/tis_node_core_p.sv
// TIS-style grid execution node: one instruction per cycle, saturating ACC/BAK, valid/ack neighbour ports.
// Optional build macro TIS_STALL_CNT_EN adds the stall_cnt output (stall cycles, saturating at 16'hFFFF).
module tis_node_core_p #(
  parameter int DW     = 11,
  parameter int SAT    = 999,
  parameter int PDEPTH = 15,
  parameter int PCW    = 4,
  parameter int IW     = DW + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PDEPTH*IW-1:0] prog,
  input  logic [PCW-1:0]       plen,
  input  logic [4*DW-1:0]      rd_data,
  input  logic [3:0]           rd_valid,
  output logic [3:0]           rd_ack,
  output logic [DW-1:0]        wr_data,
  output logic [3:0]           wr_valid,
  input  logic [3:0]           wr_ready,
  output logic [PCW-1:0]       pc,
  output logic [DW-1:0]        acc,
  output logic [DW-1:0]        bak
`ifdef TIS_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [3:0] OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3, OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7, OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11, OP_JRO = 4'd12;
  localparam logic [2:0] C_ACC = 3'd1, C_ANY = 3'd2, C_LAST = 3'd3;
  localparam logic signed [DW:0] SAT_P  = (DW+1)'(SAT);
  localparam logic signed [DW:0] NSAT_P = -SAT_P;

  function automatic logic [DW-1:0] clampSat(input logic signed [DW:0] x);
    logic [DW-1:0] r;
    if (x > SAT_P) r = SAT_P[DW-1:0];
    else if (x < NSAT_P) r = NSAT_P[DW-1:0];
    else r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic [1:0] lowIdx(input logic [3:0] m);
    logic [1:0] r;
    if (m[0]) r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else r = 2'd3;
    return r;
  endfunction

  state_t         state_r, stateNext_s;
  logic [PCW-1:0] pc_r, pcNext_s, seqPc_s, jmpTgt_s, jroTgt_s;
  logic [DW-1:0]  acc_r, accNext_s, bak_r, bakNext_s, wrData_r, wrDataNext_s, srcVal_s;
  logic [3:0]     wrValid_r, wrValidNext_s, rdAck_s, readMask_s, avail_s, wrWin_s;
  logic [2:0]     last_r, lastNext_s, dst_s, srcCode_s, dstCode_s;
  logic [IW-1:0]  instr_s;
  logic [3:0]     op_s;
  logic [DW-1:0]  src_s;
  logic [DW:0]    srcExt_s, sum_s, diff_s;
  logic [PCW+DW-1:0] jroSum_s;
  logic [1:0]     winDir_s;
  logic           imm_s, usesSrc_s, portSrc_s, active_s, jmpTake_s;

  // LAST is stored as the resolved port operand code (4..7) or NIL, so it substitutes directly.
  assign instr_s    = prog[pc_r*IW +: IW];
  assign op_s       = instr_s[IW-1 -: 4];
  assign dst_s      = instr_s[IW-5 -: 3];
  assign imm_s      = instr_s[IW-8];
  assign src_s      = instr_s[DW-1:0];
  assign srcCode_s  = (src_s[2:0] == C_LAST) ? last_r : src_s[2:0];
  assign dstCode_s  = (dst_s == C_LAST) ? last_r : dst_s;
  assign usesSrc_s  = (op_s == OP_MOV) || (op_s == OP_ADD) || (op_s == OP_SUB) || (op_s == OP_JRO);
  assign portSrc_s  = usesSrc_s && !imm_s && (srcCode_s[2] || (srcCode_s == C_ANY));
  assign readMask_s = (srcCode_s == C_ANY) ? 4'b1111 : (4'b0001 << srcCode_s[1:0]);
  assign avail_s    = rd_valid & readMask_s;
  assign winDir_s   = lowIdx(avail_s);
  assign active_s   = !rst && (state_r != WRITE) && (plen != {PCW{1'b0}}) && (pc_r < plen);
  assign wrWin_s    = wrValid_r & wr_ready;

  // Source operand selection.
  always_comb begin
    if (imm_s) srcVal_s = src_s;
    else if (srcCode_s == C_ACC) srcVal_s = acc_r;
    else if (portSrc_s) srcVal_s = rd_data[winDir_s*DW +: DW];
    else srcVal_s = {DW{1'b0}};
  end

  assign srcExt_s = {srcVal_s[DW-1], srcVal_s};
  assign sum_s    = {acc_r[DW-1], acc_r} + srcExt_s;
  assign diff_s   = {acc_r[DW-1], acc_r} - srcExt_s;
  assign seqPc_s  = (({1'b0, pc_r} + {{PCW{1'b0}}, 1'b1}) >= {1'b0, plen}) ?
                    {PCW{1'b0}} : pc_r + {{(PCW-1){1'b0}}, 1'b1};
  assign jmpTgt_s = (src_s[PCW-1:0] >= plen) ? {PCW{1'b0}} : src_s[PCW-1:0];
  assign jroSum_s = {{DW{1'b0}}, pc_r} + {{PCW{srcVal_s[DW-1]}}, srcVal_s};

  // JRO target clamped into the valid program window.
  always_comb begin
    if (jroSum_s[PCW+DW-1]) jroTgt_s = {PCW{1'b0}};
    else if (jroSum_s >= {{DW{1'b0}}, plen}) jroTgt_s = plen - {{(PCW-1){1'b0}}, 1'b1};
    else jroTgt_s = jroSum_s[PCW-1:0];
  end

  // Conditional jump decision on the current accumulator.
  always_comb begin
    case (op_s)
      OP_JMP:  jmpTake_s = 1'b1;
      OP_JEZ:  jmpTake_s = (acc_r == {DW{1'b0}});
      OP_JNZ:  jmpTake_s = (acc_r != {DW{1'b0}});
      OP_JGZ:  jmpTake_s = !acc_r[DW-1] && (acc_r != {DW{1'b0}});
      OP_JLZ:  jmpTake_s = acc_r[DW-1];
      default: jmpTake_s = 1'b0;
    endcase
  end

  // Next-state, execute and handshake logic.
  always_comb begin
    stateNext_s   = state_r;
    pcNext_s      = pc_r;
    accNext_s     = acc_r;
    bakNext_s     = bak_r;
    lastNext_s    = last_r;
    wrDataNext_s  = wrData_r;
    wrValidNext_s = wrValid_r;
    rdAck_s       = 4'b0000;
    case (state_r)
      WRITE: begin
        if (wrWin_s != 4'b0000) begin
          stateNext_s   = RUN;
          wrValidNext_s = 4'b0000;
          pcNext_s      = seqPc_s;
          if (wrValid_r == 4'b1111) lastNext_s = {1'b1, lowIdx(wrWin_s)};
          else lastNext_s = last_r;
        end else begin
          stateNext_s = WRITE;
        end
      end
      RUN, READ: begin
        if (!active_s) begin
          stateNext_s = RUN;
          pcNext_s    = {PCW{1'b0}};
        end else if (portSrc_s && (avail_s == 4'b0000)) begin
          stateNext_s = READ;
        end else begin
          stateNext_s = RUN;
          pcNext_s    = seqPc_s;
          if (portSrc_s) begin
            rdAck_s = 4'b0001 << winDir_s;
            if (srcCode_s == C_ANY) lastNext_s = {1'b1, winDir_s};
            else lastNext_s = last_r;
          end else begin
            rdAck_s = 4'b0000;
          end
          case (op_s)
            OP_MOV: begin
              if (dstCode_s == C_ACC) begin
                accNext_s = clampSat(srcExt_s);
              end else if (dstCode_s[2] || (dstCode_s == C_ANY)) begin
                stateNext_s   = WRITE;
                pcNext_s      = pc_r;
                wrDataNext_s  = srcVal_s;
                wrValidNext_s = (dstCode_s == C_ANY) ? 4'b1111 : (4'b0001 << dstCode_s[1:0]);
              end else begin
                accNext_s = acc_r;
              end
            end
            OP_SWP: begin
              accNext_s = bak_r;
              bakNext_s = acc_r;
            end
            OP_SAV: bakNext_s = acc_r;
            OP_ADD: accNext_s = clampSat(sum_s);
            OP_SUB: accNext_s = clampSat(diff_s);
            OP_NEG: accNext_s = {DW{1'b0}} - acc_r;
            OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: begin
              if (jmpTake_s) pcNext_s = jmpTgt_s;
              else pcNext_s = seqPc_s;
            end
            OP_JRO:  pcNext_s = jroTgt_s;
            default: pcNext_s = seqPc_s;
          endcase
        end
      end
      default: stateNext_s = RUN;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      pc_r      <= {PCW{1'b0}};
      acc_r     <= {DW{1'b0}};
      bak_r     <= {DW{1'b0}};
      last_r    <= 3'd0;
      wrData_r  <= {DW{1'b0}};
      wrValid_r <= 4'b0000;
    end else begin
      state_r   <= stateNext_s;
      pc_r      <= pcNext_s;
      acc_r     <= accNext_s;
      bak_r     <= bakNext_s;
      last_r    <= lastNext_s;
      wrData_r  <= wrDataNext_s;
      wrValid_r <= wrValidNext_s;
    end
  end

  assign rd_ack   = rdAck_s;
  assign wr_data  = wrData_r;
  assign wr_valid = wrValid_r;
  assign pc       = pc_r;
  assign acc      = acc_r;
  assign bak      = bak_r;

`ifdef TIS_STALL_CNT_EN
  logic [15:0] stallCnt_r;
  logic        stallCycle_s;

  assign stallCycle_s = (state_r != RUN) || (active_s && portSrc_s && (avail_s == 4'b0000));

  // Saturating count of cycles spent waiting on a neighbour.
  always_ff @(posedge clk) begin
    if (rst) stallCnt_r <= 16'h0000;
    else if (stallCycle_s && (stallCnt_r != 16'hFFFF)) stallCnt_r <= stallCnt_r + 16'h0001;
    else stallCnt_r <= stallCnt_r;
  end

  assign stall_cnt = stallCnt_r;
`endif

endmodule
